// File: rtl/piccolo_pkg.sv
// Shared constants and state encoding for the Piccolo round controller.
// Optional decryption support is enabled by the PICCOLO_DEC_EN macro in the consumers.
package piccolo_pkg;

    localparam int BLOCK_W   = 64;
    localparam int KEY80_W   = 80;
    localparam int KEY128_W  = 128;

    localparam int R80_DEF   = 25;
    localparam int R128_DEF  = 31;
    localparam int IDX_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/piccolo_round_cnt.sv
// Loadable up/down round counter that saturates at its terminal value.
// Direction is fixed at preset time; tc_o flags the final round index.
module piccolo_round_cnt
    import piccolo_pkg::*;
#(
    parameter int W = IDX_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic         down_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Terminal value: N-1 when ascending, 0 when descending.
    assign tc_o  = down_i ? (cnt_q == '0) : (cnt_q == last_i);
    assign cnt_o = cnt_q;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = down_i ? last_i : '0;
        end else if (en_i && !tc_o) begin
            cnt_d = down_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment for all registered state.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/piccolo_round_ctrl.sv
// Piccolo sequencing FSM: accept, load, N rounds, hold result until consumed.
// Define PICCOLO_DEC_EN to add dec_i/dec_o and a descending round index.
module piccolo_round_ctrl
    import piccolo_pkg::*;
#(
    parameter int R80   = R80_DEF,
    parameter int R128  = R128_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             key128_i,
`ifdef PICCOLO_DEC_EN
    input  logic             dec_i,
    output logic             dec_o,
`endif
    output logic             load_o,
    output logic             round_en_o,
    output logic [IDX_W-1:0] round_idx_o,
    output logic             last_round_o,
    output logic             mode128_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    state_e           state_q, state_d;
    logic             ready_q;
    logic             mode_q, mode_d;
    logic             dec_d;
    logic             accept;
    logic             tc;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_idx_d;

    assign accept = ready_q && in_valid_i;
    assign mode_d = accept ? key128_i : mode_q;

`ifdef PICCOLO_DEC_EN
    logic dec_q;
    assign dec_d = accept ? dec_i : dec_q;
    assign dec_o = dec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_q <= 1'b0;
        else        dec_q <= dec_d;
    end
`else
    assign dec_d = 1'b0;
`endif

    // Counter presets on the accept edge so the index is already valid during LOAD.
    assign last_idx_d = mode_d ? IDX_W'(R128 - 1) : IDX_W'(R80 - 1);

    piccolo_round_cnt #(.W(IDX_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .en_i   (state_q == ROUND),
        .down_i (dec_d),
        .last_i (last_idx_d),
        .cnt_o  (idx_q),
        .tc_o   (tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)      state_d = LOAD;
            LOAD:                     state_d = ROUND;
            ROUND:   if (tc)          state_d = HOLD;
            HOLD:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // ready_q mirrors IDLE but stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            mode_q  <= mode_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign load_o       = (state_q == LOAD);
    assign round_en_o   = (state_q == ROUND);
    assign last_round_o = (state_q == ROUND) && tc;
    assign out_valid_o  = (state_q == HOLD);
    assign round_idx_o  = idx_q;
    assign mode128_o    = mode_q;

endmodule

// File: tb/tb_piccolo_round_ctrl.sv
// Scoreboard bench for piccolo_round_ctrl: expected round trace queued on accept,
// popped by a monitor on every round_en_o cycle; dec path exercised under PICCOLO_DEC_EN.
module tb_piccolo_round_ctrl;

    localparam int N80  = 25;
    localparam int N128 = 31;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       key128_i;
    logic       load_o;
    logic       round_en_o;
    logic [4:0] round_idx_o;
    logic       last_round_o;
    logic       mode128_o;
    logic       out_valid_o;
    logic       out_ready_i;
`ifdef PICCOLO_DEC_EN
    logic       dec_i;
    logic       dec_o;
`endif

    piccolo_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .key128_i     (key128_i),
`ifdef PICCOLO_DEC_EN
        .dec_i        (dec_i),
        .dec_o        (dec_o),
`endif
        .load_o       (load_o),
        .round_en_o   (round_en_o),
        .round_idx_o  (round_idx_o),
        .last_round_o (last_round_o),
        .mode128_o    (mode128_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] idx;
        logic       last;
        logic       mode;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   load_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: every round cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (load_o) load_cnt++;
            if (round_en_o) begin
                if (sb.size() == 0) begin
                    check("round_extra", 32'(round_idx_o), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("round_idx", 32'(round_idx_o), 32'(e.idx));
                    check("round_last", 32'(last_round_o), 32'(e.last));
                    check("round_mode", 32'(mode128_o), 32'(e.mode));
                end
            end else if (last_round_o) begin
                check("last_wo_round", 32'(last_round_o), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready_o), 0);
        check({tag, "_load"},  32'(load_o), 0);
        check({tag, "_ren"},   32'(round_en_o), 0);
        check({tag, "_idx"},   32'(round_idx_o), 0);
        check({tag, "_last"},  32'(last_round_o), 0);
        check({tag, "_mode"},  32'(mode128_o), 0);
        check({tag, "_valid"}, 32'(out_valid_o), 0);
    endtask

    // Present a block, wait for accept, queue the expected trace and follow it to HOLD.
    task automatic start_txn(input bit k, input bit dec, output bit ok);
        int n;
        int guard;
        n     = k ? N128 : N80;
        guard = 0;
        load_cnt = 0;
        @(negedge clk);
        in_valid_i = 1'b1;
        key128_i   = k;
`ifdef PICCOLO_DEC_EN
        dec_i      = dec;
`endif
        while (!in_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = (guard < 50);
        check("accept_timeout", 32'(ok), 1);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{idx: dec ? 5'(n - 1 - i) : 5'(i), last: (i == n - 1), mode: k});
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        check("load_pulse", 32'(load_o), 1);
        check("busy_ready", 32'(in_ready_o), 0);
    endtask

    task automatic run_txn(input bit k, input bit dec, input int stall, input bit poke);
        int n;
        int c;
        bit ok;
        bit in_poke;
        n = k ? N128 : N80;
        out_ready_i = (stall == 0);
        start_txn(k, dec, ok);
        c = 1;
        while (!out_valid_o && c < 60) begin
            in_poke    = poke && c >= 10 && c < 13;
            in_valid_i = in_poke;
            key128_i   = in_poke ? !k : k;
            @(negedge clk);
            c++;
        end
        in_valid_i = 1'b0;
        key128_i   = k;
        check("latency", 32'(c), 32'(n + 2));
        check("hold_idx", 32'(round_idx_o), dec ? 32'd0 : 32'(n - 1));
        check("hold_mode", 32'(mode128_o), 32'(k));
        check("rounds_left", 32'(sb.size()), 0);
        check("load_count", 32'(load_cnt), 1);
`ifdef PICCOLO_DEC_EN
        check("hold_dec", 32'(dec_o), 32'(dec));
`endif
        for (int s = 0; s < stall; s++) begin
            check("bp_valid", 32'(out_valid_o), 1);
            check("bp_ready", 32'(in_ready_o), 0);
            @(negedge clk);
        end
        check("hold_valid", 32'(out_valid_o), 1);
        out_ready_i = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready_o), 1);
        check("idle_valid", 32'(out_valid_o), 0);
        sb.delete();
    endtask

    task automatic run_reset_mid();
        bit ok;
        bit seen;
        int guard;
        out_ready_i = 1'b1;
        start_txn(1'b0, 1'b0, ok);
        guard = 0;
        while (!(round_en_o && round_idx_o == 5'd12) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("reach_round12", 32'(guard < 60), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        check("valid_after_rst", 32'(seen), 0);
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid_i  = 1'b0;
        key128_i    = 1'b0;
        out_ready_i = 1'b0;
`ifdef PICCOLO_DEC_EN
        dec_i       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready_o), 1);

        run_txn(1'b0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 0, 1'b0);
        run_txn(1'b0, 1'b0, 10, 1'b0);
        run_txn(1'b1, 1'b0, 0, 1'b1);
        run_txn(1'b0, 1'b0, 0, 1'b1);
        run_reset_mid();
        run_txn(1'b1, 1'b0, 3, 1'b0);
`ifdef PICCOLO_DEC_EN
        run_txn(1'b0, 1'b1, 0, 1'b0);
        run_txn(1'b1, 1'b1, 2, 1'b1);
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
